// File: rtl/instr_fetch_buffer.sv
// Fetch stage: owns the fetch PC, issues in-order instruction memory requests and
// buffers returned words with their PC for decode, flushing on redirect.
module instr_fetch_buffer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_READY,
  input  logic        IMEM_RVALID,
  input  logic [31:0] IMEM_RDATA,
  input  logic        STALL,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  output logic [31:0] INSTRUCTION,
  output logic [31:0] PC_OUT,
  output logic        INSTR_VALID
);
  localparam int          AW     = $clog2(DEPTH);
  localparam int          CW     = AW + 1;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [CW:0] CREDIT = (CW+1)'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop;
  logic [AW-1:0] buf_wr, buf_rd;
  logic [AW-1:0] pcq_wr, pcq_rd;
  logic [31:0]   buf_pc   [DEPTH];
  logic [31:0]   buf_word [DEPTH];
  logic [31:0]   pcq      [DEPTH];
  logic [CW:0]   in_use;
  logic          accept, push, pop;

  // Buffered plus in-flight words never exceed DEPTH, so a response always has a slot.
  assign in_use      = {1'b0, count} + {1'b0, outstanding};
  assign IMEM_REQ    = !RESET && !REDIRECT && (in_use < CREDIT);
  assign IMEM_ADDR   = fetch_pc;
  assign accept      = IMEM_REQ && IMEM_READY;
  assign push        = IMEM_RVALID && (drop == '0) && !REDIRECT;
  assign pop         = INSTR_VALID && !STALL && !REDIRECT;

  assign INSTR_VALID = (count != '0);
  assign INSTRUCTION = INSTR_VALID ? buf_word[buf_rd] : NOP;
  assign PC_OUT      = INSTR_VALID ? buf_pc[buf_rd] : 32'h0;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      fetch_pc    <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
      buf_wr      <= '0;
      buf_rd      <= '0;
      pcq_wr      <= '0;
      pcq_rd      <= '0;
    end else begin
      if (accept)      pcq_wr <= pcq_wr + AW'(1);
      if (IMEM_RVALID) pcq_rd <= pcq_rd + AW'(1);
      outstanding <= outstanding + CW'(accept) - CW'(IMEM_RVALID);

      if (REDIRECT) begin
        // Every word still in flight belongs to the old path; a same-cycle response is discarded here.
        fetch_pc <= {REDIRECT_PC[31:2], 2'b00};
        count    <= '0;
        buf_wr   <= '0;
        buf_rd   <= '0;
        drop     <= outstanding - CW'(IMEM_RVALID);
      end else begin
        if (accept) fetch_pc <= fetch_pc + 32'd4;
        if (push)   buf_wr   <= buf_wr + AW'(1);
        if (pop)    buf_rd   <= buf_rd + AW'(1);
        count <= count + CW'(push) - CW'(pop);
        if (IMEM_RVALID && (drop != '0)) drop <= drop - CW'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (accept) pcq[pcq_wr] <= fetch_pc;
    if (push) begin
      buf_pc[buf_wr]   <= pcq[pcq_rd];
      buf_word[buf_wr] <= IMEM_RDATA;
    end
  end

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Bench for instr_fetch_buffer: behavioural memory plus an epoch-tagged queue model
// of the fetch path, checked every cycle.
module tb_instr_fetch_buffer;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_READY = 1'b1;
  logic        IMEM_RVALID = 1'b0;
  logic [31:0] IMEM_RDATA = 32'h0;
  logic        STALL = 1'b0;
  logic        REDIRECT = 1'b0;
  logic [31:0] REDIRECT_PC = 32'h0;
  logic [31:0] INSTRUCTION;
  logic [31:0] PC_OUT;
  logic        INSTR_VALID;

  instr_fetch_buffer #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RESET(RESET),
    .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .IMEM_READY(IMEM_READY),
    .IMEM_RVALID(IMEM_RVALID), .IMEM_RDATA(IMEM_RDATA),
    .STALL(STALL), .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC),
    .INSTRUCTION(INSTRUCTION), .PC_OUT(PC_OUT), .INSTR_VALID(INSTR_VALID)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic [31:0] addr; int epoch; int due; } flight_t;
  typedef struct { logic [31:0] pc; logic [31:0] word; } entry_t;

  flight_t     inflight[$];
  entry_t      bufq[$];
  logic [31:0] fetch_exp;
  int          epoch, cyc, last_due, mem_lat;
  int          total = 0;
  int          bad = 0;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    inflight.delete();
    bufq.delete();
    fetch_exp = RESET_PC;
    last_due  = 0;
  endtask

  task automatic check_outputs(input logic exp_req);
    chk("imem_req", {31'b0, IMEM_REQ}, {31'b0, exp_req});
    chk("imem_addr", IMEM_ADDR, fetch_exp);
    chk("instr_valid", {31'b0, INSTR_VALID}, {31'b0, bufq.size() > 0});
    chk("instruction", INSTRUCTION, (bufq.size() > 0) ? bufq[0].word : NOP);
    chk("pc_out", PC_OUT, (bufq.size() > 0) ? bufq[0].pc : 32'h0);
  endtask

  task automatic step(input logic st, input logic rd, input logic [31:0] rpc, input logic rdy);
    logic    rv, exp_req;
    flight_t f, h;
    @(negedge CLK);
    RESET       = 1'b0;
    STALL       = st;
    REDIRECT    = rd;
    REDIRECT_PC = rpc;
    IMEM_READY  = rdy;
    rv          = (inflight.size() > 0) && (inflight[0].due <= cyc);
    IMEM_RVALID = rv;
    IMEM_RDATA  = rv ? word_of(inflight[0].addr) : $urandom;
    #1;
    exp_req = !rd && ((bufq.size() + inflight.size()) < DEPTH);
    check_outputs(exp_req);
    @(posedge CLK);
    if (!rd && !st && bufq.size() > 0) void'(bufq.pop_front());
    if (rv) begin
      h = inflight.pop_front();
      if (!rd && h.epoch == epoch) bufq.push_back('{pc: h.addr, word: word_of(h.addr)});
    end
    if (exp_req && rdy) begin
      f.addr  = fetch_exp;
      f.epoch = epoch;
      f.due   = (cyc + mem_lat > last_due + 1) ? cyc + mem_lat : last_due + 1;
      last_due = f.due;
      inflight.push_back(f);
      fetch_exp = fetch_exp + 32'd4;
    end
    if (rd) begin
      epoch++;
      bufq.delete();
      fetch_exp = {rpc[31:2], 2'b00};
    end
    cyc++;
  endtask

  task automatic pulse_reset();
    @(negedge CLK);
    #2;
    RESET       = 1'b1;
    IMEM_RVALID = 1'b0;
    REDIRECT    = 1'b0;
    STALL       = 1'b0;
    IMEM_READY  = 1'b1;
    model_reset();
    #1;
    check_outputs(1'b0);
  endtask

  initial begin
    epoch   = 0;
    cyc     = 0;
    mem_lat = 1;
    model_reset();
    #1;
    check_outputs(1'b0);

    repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1);
    repeat (3) step(1'b0, 1'b0, 32'h0, 1'b0);
    repeat (3) step(1'b0, 1'b0, 32'h0, 1'b1);
    repeat (5) step(1'b1, 1'b0, 32'h0, 1'b1);
    repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1);

    mem_lat = 2;
    repeat (4) step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 32'h0000_0100, 1'b1);
    repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1);

    mem_lat = 1;
    repeat (4) step(1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b1, 32'h0000_0203, 1'b1);
    repeat (5) step(1'b0, 1'b0, 32'h0, 1'b1);

    step(1'b0, 1'b1, 32'h0000_0400, 1'b1);
    step(1'b0, 1'b1, 32'h0000_0800, 1'b1);
    repeat (4) step(1'b0, 1'b0, 32'h0, 1'b1);

    pulse_reset();
    repeat (5) step(1'b0, 1'b0, 32'h0, 1'b1);

    for (int i = 0; i < 1500; i++) begin
      mem_lat = $urandom_range(1, 3);
      if (i == 750) pulse_reset();
      step(($urandom % 4) == 0, ($urandom % 20) == 0, $urandom, ($urandom % 4) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
